// File: rtl/dtv1_delta_enc_pkg.sv
// Shared widths, token layout and FSM encoding for the DTV1 delta encoder.
package dtv1_delta_enc_pkg;
  localparam int DATA_W  = 16;
  localparam int VEC_LEN = 64;
  localparam int IDX_W   = $clog2(VEC_LEN);
  localparam int TOK_W   = 1 + IDX_W + DATA_W;

  typedef struct packed {
    logic                     last;
    logic [IDX_W-1:0]         idx;
    logic signed [DATA_W-1:0] delta;
  } dtv1_tok_t;

  typedef enum logic [1:0] {IDLE, SCAN, EOF, DONE} dtv1_enc_state_t;
endpackage

// File: rtl/dtv1_delta_enc_if.sv
// Element input handshake plus FIFO push port of the delta encoder.
interface dtv1_delta_enc_if;
  import dtv1_delta_enc_pkg::*;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_data;
  logic                     fifo_push;
  logic                     fifo_full;
  dtv1_tok_t                fifo_din;

  modport master (input in_valid, in_data, fifo_full,
                  output in_ready, fifo_push, fifo_din);
  modport slave  (output in_valid, in_data, fifo_full,
                  input in_ready, fifo_push, fifo_din);
endinterface

// File: rtl/dtv1_delta_enc_cmp.sv
// Pure-combinational delta, magnitude threshold test and saturation.
module dtv1_delta_enc_cmp #(
  parameter int DATA_W = 16
) (
  input  logic signed [DATA_W-1:0] x_i,
  input  logic signed [DATA_W-1:0] prev_i,
  input  logic        [DATA_W-1:0] thr_i,
  output logic                     hit_o,
  output logic signed [DATA_W-1:0] d_sat_o
);
  logic signed [DATA_W:0] d;
  logic        [DATA_W:0] mag;

  // One extra bit keeps the full-range difference exact before clamping
  assign d   = $signed({x_i[DATA_W-1], x_i}) - $signed({prev_i[DATA_W-1], prev_i});
  assign mag = d[DATA_W] ? $unsigned(-d) : $unsigned(d);
  assign hit_o = (mag >= {1'b0, thr_i});

  always_comb begin
    d_sat_o = d[DATA_W-1:0];
    if (d[DATA_W] != d[DATA_W-1])
      d_sat_o = d[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
  end
endmodule

// File: rtl/dtv1_delta_enc.sv
// Sparse delta encoder: emits supra-threshold deltas and an EOF token per frame.
module dtv1_delta_enc
  import dtv1_delta_enc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] thr_i,
  input  logic              clear_i,
  input  logic              start_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [IDX_W:0]    nz_cnt_o,
  dtv1_delta_enc_if.master  bus
);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VEC_LEN - 1);

  dtv1_enc_state_t          state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [IDX_W:0]           nz_q, nz_d;
  logic [DATA_W-1:0]        thr_q, thr_d;
  logic signed [DATA_W-1:0] prev_q [VEC_LEN];
  logic                     clr, wr_en, accept, hit;
  logic signed [DATA_W-1:0] d_sat;

  dtv1_delta_enc_cmp #(.DATA_W(DATA_W)) u_cmp (
    .x_i    (bus.in_data),
    .prev_i (prev_q[idx_q]),
    .thr_i  (thr_q),
    .hit_o  (hit),
    .d_sat_o(d_sat)
  );

  assign accept   = (state_q == SCAN) && bus.in_valid && !bus.fifo_full;
  assign nz_cnt_o = nz_q;

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    nz_d          = nz_q;
    thr_d         = thr_q;
    clr           = 1'b0;
    wr_en         = 1'b0;
    busy_o        = 1'b0;
    done_o        = 1'b0;
    bus.in_ready  = 1'b0;
    bus.fifo_push = 1'b0;
    bus.fifo_din  = '0;
    case (state_q)
      IDLE: begin
        clr = clear_i;
        if (start_i) begin
          thr_d   = thr_i;
          idx_d   = '0;
          nz_d    = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        busy_o       = 1'b1;
        bus.in_ready = !bus.fifo_full;
        if (accept) begin
          idx_d = idx_q + IDX_W'(1);
          if (hit) begin
            bus.fifo_push = 1'b1;
            bus.fifo_din  = '{last: 1'b0, idx: idx_q, delta: d_sat};
            nz_d          = nz_q + (IDX_W+1)'(1);
            wr_en         = 1'b1;
          end
          if (idx_q == LAST_IDX) state_d = EOF;
        end
      end
      EOF: begin
        busy_o = 1'b1;
        if (!bus.fifo_full) begin
          bus.fifo_push = 1'b1;
          bus.fifo_din  = '{last: 1'b1, idx: LAST_IDX, delta: '0};
          state_d       = DONE;
        end
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      nz_q    <= '0;
      thr_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      nz_q    <= nz_d;
      thr_q   <= thr_d;
    end
  end

  // Reference update mirrors what the downstream accumulator reconstructs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < VEC_LEN; i++) prev_q[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < VEC_LEN; i++) prev_q[i] <= '0;
    end else if (wr_en) begin
      prev_q[idx_q] <= prev_q[idx_q] + d_sat;
    end
  end
endmodule

// File: tb/tb_dtv1_delta_enc.sv
// Directed + randomized frames checked against an integer reference of the encoder rules.
module tb_dtv1_delta_enc;
  import dtv1_delta_enc_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] thr;
  logic              clear, start;
  logic              busy, done;
  logic [IDX_W:0]    nz;

  dtv1_delta_enc_if bus();

  dtv1_delta_enc dut (
    .clk     (clk),
    .rst     (rst),
    .thr_i   (thr),
    .clear_i (clear),
    .start_i (start),
    .busy_o  (busy),
    .done_o  (done),
    .nz_cnt_o(nz),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int mprev [VEC_LEN];
  int xv    [VEC_LEN];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int clamp(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Runs one frame from IDLE. Called and returns at posedge+1.
  task automatic run_frame(input int t, input int stall_at, input int stall_len,
                           input int eof_stall, input int vprob, input int abort_at,
                           input bit with_clear, input bit hold_start);
    logic [31:0] expq[$];
    int nzexp, k, cyc, eofw, d, mag, ds;
    bit got_done;
    nzexp = 0;
    if (with_clear) foreach (mprev[i]) mprev[i] = 0;
    for (int i = 0; i < VEC_LEN; i++) begin
      d   = xv[i] - mprev[i];
      mag = (d < 0) ? -d : d;
      if (mag >= t) begin
        ds = clamp(d);
        expq.push_back(32'({1'b0, IDX_W'(i), DATA_W'(ds)}));
        mprev[i] += ds;
        nzexp++;
      end
    end
    expq.push_back(32'({1'b1, IDX_W'(VEC_LEN-1), DATA_W'(0)}));

    thr = DATA_W'(t); start = 1'b1; clear = with_clear;
    @(posedge clk); #1;
    start = 1'b0; clear = 1'b0;
    chk("busy_after_start", busy, 1);
    k = 0; cyc = 0; eofw = 0; got_done = 0;
    while (!got_done && cyc < 3000) begin
      bus.in_valid = ($urandom_range(99) < vprob);
      bus.in_data  = DATA_W'(xv[(k < VEC_LEN) ? k : 0]);
      start        = hold_start && (k < VEC_LEN);
      if (k < VEC_LEN) bus.fifo_full = (cyc >= stall_at) && (cyc < stall_at + stall_len);
      else begin
        bus.fifo_full = (eofw < eof_stall);
        eofw++;
      end
      if (abort_at >= 0 && k == abort_at) begin
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_push", bus.fifo_push, 0);
        chk("abort_ready", bus.in_ready, 0);
        rst = 1'b0; start = 1'b0;
        bus.in_valid = 1'b0; bus.fifo_full = 1'b0;
        foreach (mprev[i]) mprev[i] = 0;
        @(posedge clk); #1;
        return;
      end
      @(negedge clk);
      if (bus.fifo_full) begin
        chk("stall_ready", bus.in_ready, 0);
        chk("stall_push", bus.fifo_push, 0);
      end
      if (bus.fifo_push) begin
        chk("token_overrun", 32'(expq.size() == 0), 0);
        if (expq.size() != 0) chk("token", 32'(bus.fifo_din), expq.pop_front());
      end
      if (bus.in_valid && bus.in_ready) k++;
      if (done) begin
        got_done = 1;
        chk("busy_in_done", busy, 0);
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0; bus.in_valid = 1'b0; bus.fifo_full = 1'b0;
    chk("frame_timeout", got_done, 1);
    chk("tokens_left", expq.size(), 0);
    chk("elements", k, VEC_LEN);
    chk("nz_cnt", nz, nzexp);
    chk("done_pulse", done, 0);
    chk("busy_idle", busy, 0);
  endtask

  initial begin
    rst = 1'b1; thr = '0; clear = 1'b0; start = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.fifo_full = 1'b0;
    foreach (mprev[i]) mprev[i] = 0;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", bus.in_ready, 0);
    chk("rst_push", bus.fifo_push, 0);
    chk("rst_din", 32'(bus.fifo_din), 0);
    chk("rst_nz", nz, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // In IDLE, valid elements must be refused
    bus.in_valid = 1'b1; bus.in_data = 16'h1234;
    @(negedge clk);
    chk("idle_ready", bus.in_ready, 0);
    chk("idle_push", bus.fifo_push, 0);
    @(posedge clk); #1; bus.in_valid = 1'b0;

    // Ramp frames: first is mostly hits, following ones converge to zero tokens
    foreach (xv[i]) xv[i] = i;
    run_frame(4, 1000, 0, 0, 100, -1, 0, 0);
    chk("ramp1_nz", nz, 60);
    run_frame(4, 1000, 0, 0, 100, -1, 0, 1);
    run_frame(4, 1000, 0, 0, 100, -1, 0, 0);
    chk("ramp3_nz", nz, 0);

    // Saturation at both rails
    foreach (xv[i]) xv[i] = mprev[i];
    xv[0] = -32768;
    run_frame(1, 1000, 0, 0, 100, -1, 1, 0);
    xv[0] = 32767;
    run_frame(1, 1000, 0, 0, 100, -1, 0, 0);
    chk("sat_nz1", nz, 1);
    run_frame(1, 1000, 0, 0, 100, -1, 0, 0);
    chk("sat_nz2", nz, 1);

    // Backpressure mid-scan and during EOF, with input bubbles
    foreach (xv[i]) xv[i] = int'($urandom_range(2000)) - 1000;
    run_frame(50, 20, 10, 5, 70, -1, 0, 0);

    // Dense mode with unchanged inputs
    foreach (xv[i]) xv[i] = mprev[i];
    run_frame(0, 1000, 0, 0, 100, -1, 0, 0);
    chk("dense_nz", nz, 64);

    // Clear in IDLE restores the after-reset behaviour
    clear = 1'b1; @(posedge clk); #1; clear = 1'b0;
    foreach (mprev[i]) mprev[i] = 0;
    foreach (xv[i]) xv[i] = i;
    run_frame(4, 1000, 0, 0, 100, -1, 0, 0);
    chk("clear_nz", nz, 60);

    // Reset mid-frame, then a fresh frame starts from prev=0
    foreach (xv[i]) xv[i] = int'($urandom_range(65535)) - 32768;
    run_frame(10, 1000, 0, 0, 100, 30, 0, 0);
    foreach (xv[i]) xv[i] = i;
    run_frame(4, 1000, 0, 0, 100, -1, 0, 0);
    chk("post_abort_nz", nz, 60);

    // Random frames over the full range
    for (int f = 0; f < 5; f++) begin
      foreach (xv[i]) xv[i] = int'($urandom_range(65535)) - 32768;
      run_frame(int'($urandom_range(40000)), int'($urandom_range(80)),
                int'($urandom_range(12)), int'($urandom_range(4)),
                60 + int'($urandom_range(40)), -1, (f == 2), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
